// File: rtl/cipher_prog_seq.sv
// Program sequencer: selects one of NUM_PROG external instruction ROMs and streams
// a run-time-length program to the datapath with start/busy/done, stall and err.
module cipher_prog_seq #(
  parameter int INST_W   = 16,
  parameter int PC_W     = 7,
  parameter int NUM_PROG = 6,
  localparam int SEL_W   = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SEL_W-1:0]           prog_sel,
  input  logic [PC_W:0]              prog_len,
  input  logic                       stall,
  output logic [NUM_PROG-1:0]        rom_en,
  output logic [PC_W-1:0]            rom_addr,
  input  logic [NUM_PROG*INST_W-1:0] rom_data,
  output logic                       inst_valid,
  output logic [INST_W-1:0]          inst,
  output logic [PC_W-1:0]            inst_pc,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [PC_W:0] LEN_MAX = (PC_W+1)'(2**PC_W);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [PC_W:0]     len_q, len_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              issue;
  logic              req_ok;
  logic              last_issue;
  logic [NUM_PROG-1:0] sel_onehot;
  logic [INST_W-1:0] rom_word;

  assign req_ok     = (int'(prog_sel) < NUM_PROG) && (prog_len != '0) && (prog_len <= LEN_MAX);
  // Full PC_W+1 compare so a length of 2^PC_W ends at pc = 2^PC_W-1 without wrap.
  assign last_issue = ({1'b0, pc_q} == (len_q - (PC_W+1)'(1)));

  // Stage 0: control FSM, program counter and fetch issue
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    pc_d      = pc_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_ok) begin
            sel_d   = prog_sel;
            len_d   = prog_len;
            pc_d    = '0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          issue     = 1'b1;
          pend_d    = 1'b1;
          pend_pc_d = pc_q;
          if (last_issue) begin
            state_d = S_DRAIN;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        pc_d    = '0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      pc_q      <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Stage 1: ROM select decode and read-data return mux
  always_comb begin
    sel_onehot = '0;
    rom_word   = '0;
    for (int k = 0; k < NUM_PROG; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_onehot[k] = 1'b1;
        rom_word      = rom_data[k*INST_W +: INST_W];
      end
    end
  end

  assign rom_en     = issue ? sel_onehot : '0;
  assign rom_addr   = pc_q;
  assign inst_valid = pend_q;
  assign inst       = pend_q ? rom_word : '0;
  assign inst_pc    = pend_pc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cipher_prog_seq.sv
// Bench for cipher_prog_seq: external ROM model, table-driven and random runs checked
// against a timeline model built from issue cycles, plus hand-written corner sequences.
module tb_cipher_prog_seq;

  localparam int INST_W   = 16;
  localparam int PC_W     = 7;
  localparam int NUM_PROG = 6;
  localparam int SEL_W    = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;
  localparam int MAXC     = 512;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [SEL_W-1:0]           prog_sel;
  logic [PC_W:0]              prog_len;
  logic                       stall;
  logic [NUM_PROG-1:0]        rom_en;
  logic [PC_W-1:0]            rom_addr;
  logic [NUM_PROG*INST_W-1:0] rom_data;
  logic                       inst_valid;
  logic [INST_W-1:0]          inst;
  logic [PC_W-1:0]            inst_pc;
  logic                       busy;
  logic                       done;
  logic                       err;

  int n_checks = 0;
  int n_fail   = 0;
  bit stall_pat [MAXC];

  cipher_prog_seq #(.INST_W(INST_W), .PC_W(PC_W), .NUM_PROG(NUM_PROG)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel), .prog_len(prog_len),
    .stall(stall), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] rom_word(input int k, input int a);
    return INST_W'(((k + 1) * 4951) ^ (a * 515) ^ 23040);
  endfunction

  // External ROMs: registered read, one cycle latency, output held when not enabled
  logic [INST_W-1:0] rom_q [NUM_PROG];
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PROG; k++)
      if (rom_en[k]) rom_q[k] <= rom_word(k, int'(rom_addr));
  end
  always_comb begin
    rom_data = '0;
    for (int k = 0; k < NUM_PROG; k++) rom_data[k*INST_W +: INST_W] = rom_q[k];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".rom_en"}, rom_en, 0);
    chk({tag, ".rom_addr"}, rom_addr, 0);
    chk({tag, ".inst_valid"}, inst_valid, 0);
    chk({tag, ".inst"}, inst, 0);
    chk({tag, ".inst_pc"}, inst_pc, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  // One run from an idle sequencer; expected timeline derived from the list of issue cycles.
  task automatic do_run(input int sel, input int len, output int done_seen, output int err_seen);
    int  issue_at[$];
    int  t_last, last_c, nprior, e_idx;
    bit  legal, e_en, e_valid, e_busy, e_done, e_err;
    int  e_addr;
    legal = (sel < NUM_PROG) && (len >= 1) && (len <= 2**PC_W);
    issue_at.delete();
    t_last = 0;
    if (legal) begin
      for (int c = 1; issue_at.size() < len; c++)
        if (!stall_pat[c]) issue_at.push_back(c);
      t_last = issue_at[len-1];
      last_c = t_last + 2;
    end else begin
      last_c = 3;
    end
    done_seen = 0;
    err_seen  = 0;
    next_cycle();
    start = 1'b1; prog_sel = sel[SEL_W-1:0]; prog_len = len[PC_W:0]; stall = stall_pat[0];
    for (int c = 1; c <= last_c; c++) begin
      next_cycle();
      start = 1'b0; stall = stall_pat[c];
      @(negedge clk);
      e_en = 0; e_valid = 0; e_idx = 0; nprior = 0;
      foreach (issue_at[i]) begin
        if (issue_at[i] == c) e_en = 1;
        if (issue_at[i] == c - 1) begin e_valid = 1; e_idx = i; end
        if (issue_at[i] < c) nprior++;
      end
      if (legal) begin
        e_addr = (c <= t_last) ? nprior : (c == t_last + 1) ? len - 1 : 0;
        e_busy = (c <= t_last + 1);
        e_done = (c == t_last + 2);
        e_err  = 0;
      end else begin
        e_addr = 0; e_busy = 0; e_done = 0; e_err = (c == 1);
      end
      chk("rom_en", rom_en, e_en ? (longint'(1) << sel) : 0);
      chk("rom_addr", rom_addr, e_addr);
      chk("inst_valid", inst_valid, e_valid);
      chk("inst", inst, e_valid ? rom_word(sel, e_idx) : 0);
      if (e_valid) chk("inst_pc", inst_pc, e_idx);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      if (done === 1'b1) done_seen = c;
      if (err === 1'b1) err_seen = c;
    end
  endtask

  typedef struct {
    int          sel;
    int          len;
    logic [15:0] smask;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ds, es, sel, len;
    tbl[0] = '{2,   4, 16'h0000,   6, 0};
    tbl[1] = '{2,   4, 16'h000C,   8, 0};
    tbl[2] = '{6,   4, 16'h0000,   0, 1};
    tbl[3] = '{0,   0, 16'h0000,   0, 1};
    tbl[4] = '{7,   1, 16'h0000,   0, 1};
    tbl[5] = '{1, 129, 16'h0000,   0, 1};
    tbl[6] = '{5,   1, 16'h0000,   3, 0};
    tbl[7] = '{1,   3, 16'h0002,   6, 0};
    tbl[8] = '{3, 128, 16'h0000, 130, 0};
    tbl[9] = '{0, 128, 16'h5555, 137, 0};

    rst = 1'b1; start = 1'b0; prog_sel = '0; prog_len = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset");

    foreach (tbl[v]) begin
      for (int c = 0; c < MAXC; c++) stall_pat[c] = (c < 16) ? tbl[v].smask[c] : 1'b0;
      do_run(tbl[v].sel, tbl[v].len, ds, es);
      chk($sformatf("tbl%0d.done_cycle", v), ds, tbl[v].exp_done);
      chk($sformatf("tbl%0d.err_cycle", v), es, tbl[v].exp_err);
    end

    // Start while busy is ignored; start in the done cycle is accepted
    next_cycle();
    start = 1'b1; prog_sel = 5; prog_len = 2; stall = 1'b0;
    next_cycle(); start = 1'b0;
    @(negedge clk);
    chk("seqA.c1.rom_en", rom_en, 6'b100000);
    chk("seqA.c1.busy", busy, 1);
    next_cycle(); start = 1'b1; prog_sel = 1; prog_len = 1;
    @(negedge clk);
    chk("seqA.c2.rom_addr", rom_addr, 1);
    chk("seqA.c2.inst", inst, rom_word(5, 0));
    next_cycle(); start = 1'b0;
    @(negedge clk);
    chk("seqA.c3.err", err, 0);
    chk("seqA.c3.inst", inst, rom_word(5, 1));
    chk("seqA.c3.inst_pc", inst_pc, 1);
    chk("seqA.c3.rom_en", rom_en, 0);
    next_cycle(); start = 1'b1; prog_sel = 1; prog_len = 1;
    @(negedge clk);
    chk("seqA.c4.done", done, 1);
    chk("seqA.c4.busy", busy, 0);
    next_cycle(); start = 1'b0;
    @(negedge clk);
    chk("seqA.c5.rom_en", rom_en, 6'b000010);
    chk("seqA.c5.rom_addr", rom_addr, 0);
    next_cycle();
    @(negedge clk);
    chk("seqA.c6.inst_valid", inst_valid, 1);
    chk("seqA.c6.inst", inst, rom_word(1, 0));
    chk("seqA.c6.done", done, 0);
    next_cycle();
    @(negedge clk);
    chk("seqA.c7.done", done, 1);
    next_cycle();
    @(negedge clk);
    chk("seqA.c8.done", done, 0);

    // Reset mid-run aborts with no done, then a fresh run starts at pc 0
    next_cycle();
    start = 1'b1; prog_sel = 0; prog_len = 8;
    next_cycle(); start = 1'b0;
    next_cycle();
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("seqB.c4");
    for (int c = 5; c <= 12; c++) begin
      next_cycle();
      @(negedge clk);
      chk("seqB.post.inst_valid", inst_valid, 0);
      chk("seqB.post.done", done, 0);
      chk("seqB.post.busy", busy, 0);
    end
    for (int c = 0; c < MAXC; c++) stall_pat[c] = 1'b0;
    do_run(0, 3, ds, es);
    chk("seqB.rerun.done_cycle", ds, 5);

    // Randomised runs, including illegal selects and boundary lengths
    for (int r = 0; r < 25; r++) begin
      sel = $urandom_range(0, 7);
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = 128;
        2:       len = 129;
        default: len = $urandom_range(1, 40);
      endcase
      for (int c = 0; c < MAXC; c++) stall_pat[c] = (c < 300) && ($urandom_range(0, 9) < 3);
      do_run(sel, len, ds, es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
